// File: rtl/grf_read_port_if.sv
// grf_read_port_if: D-stage read and W-stage write bundle of the general register file
interface grf_read_port_if #(parameter int DW = 32, parameter int AW = 5, parameter int CW = 32);
  logic [AW-1:0] A1;
  logic [AW-1:0] A2;
  logic [DW-1:0] RD1;
  logic [DW-1:0] RD2;
  logic          RFWr;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD;
  logic [31:0]   WPC;
  logic [CW-1:0] wr_cnt;
  modport master (output A1, A2, RFWr, A3, WD, WPC, input RD1, RD2, wr_cnt);
  modport slave (input A1, A2, RFWr, A3, WD, WPC, output RD1, RD2, wr_cnt);
endinterface

// File: rtl/grf_read_port.sv
// grf_read_port: MIPS register file with two bypassed read ports and a retired-write counter; GRF_LOG_EN enables write logging
module grf_read_port #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 32
) (
  input logic clk,
  input logic reset,
  grf_read_port_if.slave b
);
  localparam int NREG = 2 ** AW;
  logic [DW-1:0] r_reg [NREG];
  logic [CW-1:0] r_wr_cnt;
  logic          w_we;
  assign w_we = b.RFWr && (b.A3 != '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_reg[i] <= '0;
      r_wr_cnt <= '0;
    end else if (w_we) begin
      r_reg[b.A3] <= b.WD;
      r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end
  // W->D bypass: a same-cycle write wins over the stored value
  assign b.RD1 = (b.A1 == '0) ? '0 : (b.RFWr && b.A3 == b.A1) ? b.WD : r_reg[b.A1];
  assign b.RD2 = (b.A2 == '0) ? '0 : (b.RFWr && b.A3 == b.A2) ? b.WD : r_reg[b.A2];
  assign b.wr_cnt = r_wr_cnt;
`ifdef GRF_LOG_EN
  always_ff @(posedge clk) begin
    if (!reset && w_we) $display("%d@%h: $%d <= %h", $time, b.WPC, b.A3, b.WD);
  end
`else
  logic w_unused_wpc;
  assign w_unused_wpc = ^b.WPC;
`endif
endmodule

// File: tb/tb_grf_read_port.sv
// tb_grf_read_port: scoreboard bench with directed cases and random traffic against an array model
module tb_grf_read_port;
  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] cnt;
  } exp_t;
  logic clk = 0;
  logic reset;
  grf_read_port_if #(.DW(32), .AW(5), .CW(32)) bus ();
  grf_read_port #(.DW(32), .AW(5), .CW(32)) dut (.clk(clk), .reset(reset), .b(bus));
  always #5 clk = ~clk;
  logic [31:0] mem [32];
  logic [31:0] cnt;
  exp_t q [$];
  event ev;
  int checks = 0;
  int passed = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask
  function automatic logic [31:0] rd(input logic [4:0] a, input logic we, input logic [4:0] a3, input logic [31:0] wd);
    if (a == 0) return 0;
    if (we && a3 == a) return wd;
    return mem[a];
  endfunction
  task automatic drive(input logic rst, input logic [4:0] a1, input logic [4:0] a2, input logic we,
                       input logic [4:0] a3, input logic [31:0] wd, input logic chk);
    exp_t e;
    @(negedge clk);
    reset = rst;
    bus.A1 = a1;
    bus.A2 = a2;
    bus.RFWr = we;
    bus.A3 = a3;
    bus.WD = wd;
    bus.WPC = $urandom;
    if (chk) begin
      e.rd1 = rd(a1, we, a3, wd);
      e.rd2 = rd(a2, we, a3, wd);
      e.cnt = cnt;
      q.push_back(e);
      ->ev;
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 0;
      cnt = 0;
    end else if (we && a3 != 0) begin
      mem[a3] = wd;
      cnt = cnt + 1;
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(ev);
      #1;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard: queue empty at %0t", $time);
      end else begin
        e = q.pop_front();
        check("RD1", bus.RD1, e.rd1);
        check("RD2", bus.RD2, e.rd2);
        check("wr_cnt", bus.wr_cnt, e.cnt);
      end
    end
  end
  initial begin : driver
    for (int i = 0; i < 32; i++) mem[i] = 0;
    cnt = 0;
    reset = 1;
    bus.A1 = 0; bus.A2 = 0; bus.RFWr = 0; bus.A3 = 0; bus.WD = 0; bus.WPC = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 5, 31, 0, 0, 0, 1);
    drive(0, 8, 0, 1, 8, 32'h12345678, 1);
    drive(0, 8, 5, 0, 0, 0, 1);
    drive(0, 9, 9, 1, 9, 32'hDEADBEEF, 1);
    drive(0, 9, 9, 0, 9, 0, 1);
    drive(0, 0, 8, 1, 0, 32'hFFFFFFFF, 1);
    drive(0, 0, 8, 0, 0, 0, 1);
    drive(1, 8, 9, 1, 8, 32'h1, 1);
    drive(0, 8, 9, 0, 0, 0, 1);
    drive(0, 31, 31, 1, 31, 32'h3008, 1);
    drive(0, 31, 1, 0, 0, 0, 1);
    for (int n = 0; n < 400; n++)
      drive($urandom_range(0, 99) < 3, 5'($urandom), 5'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, 1);
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard: %0d entries left unchecked", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
